// File: rtl/fetch_unit2.sv
// fetch_unit2: instruction fetch and field-extract stage feeding the cpu2
// operand-read/ALU stage. Fetches words over a rd/ready handshake, buffers
// them and presents decoded fields with a valid/accept handshake. Handles
// jump redirects, including ones that land while a read is still in flight.
//
// Build option: define FETCH_PREFETCH_EN for a two-entry buffer that keeps
// fetching while the head waits (one instruction per cycle); otherwise a
// single-entry buffer is used (one instruction per two cycles at best).
module fetch_unit2 #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic             o_mem_rd,
    input  logic             i_mem_ready,
    input  logic [WIDTH-1:0] i_mem_rdata,
    input  logic             i_jmp_en,
    input  logic [WIDTH-1:0] i_jmp_addr,
    output logic             o_iv,
    input  logic             i_iaccept,
    output logic [5:0]       o_op,
    output logic [3:0]       o_rd_idx,
    output logic [3:0]       o_ra_idx,
    output logic [3:0]       o_rb_idx,
    output logic [15:0]      o_im,
    output logic [WIDTH-1:0] o_ipc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;          // next fetch address, or pending jump target while draining
    logic [WIDTH-1:0] r_mem_addr;
    logic             r_mem_rd;
    logic [1:0]       r_count;       // number of valid buffer entries
    logic [WIDTH-1:0] r_head_word;
    logic [WIDTH-1:0] r_head_pc;
`ifdef FETCH_PREFETCH_EN
    logic [WIDTH-1:0] r_tail_word;
    logic [WIDTH-1:0] r_tail_pc;
    logic [WIDTH-1:0] w_tail_word_n;
    logic [WIDTH-1:0] w_tail_pc_n;
    logic             w_wr_tail;
`endif

    logic             w_accept;
    logic             w_fill;
    logic             w_pending;
    logic [1:0]       w_count_n;
    logic             w_room;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_head_word_n;
    logic [WIDTH-1:0] w_head_pc_n;

    // The consumer's accept always completes, even alongside a jump; a
    // returning word is only kept when it belongs to a live REQ with no jump.
    assign w_accept  = (r_count != 2'd0) & i_iaccept;
    assign w_fill    = (r_state == S_REQ) & i_mem_ready & ~i_jmp_en;
    assign w_pending = ((r_state == S_REQ) | (r_state == S_DRAIN)) & ~i_mem_ready;
    assign w_count_n = r_count - {1'b0, w_accept} + {1'b0, w_fill};
    assign w_room    = (w_count_n < DEPTH);
    assign w_pc_inc  = r_pc + {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef FETCH_PREFETCH_EN
    // New word lands in the tail slot when an entry remains after the accept.
    assign w_wr_tail = ((r_count - {1'b0, w_accept}) != 2'd0);

    // Next buffer contents: shift on accept, then write the returning word.
    always_comb begin
        w_head_word_n = r_head_word;
        w_head_pc_n   = r_head_pc;
        w_tail_word_n = r_tail_word;
        w_tail_pc_n   = r_tail_pc;
        if (w_accept) begin
            w_head_word_n = r_tail_word;
            w_head_pc_n   = r_tail_pc;
        end else begin
            w_head_word_n = r_head_word;
            w_head_pc_n   = r_head_pc;
        end
        if (w_fill && !w_wr_tail) begin
            w_head_word_n = i_mem_rdata;
            w_head_pc_n   = r_pc;
        end else if (w_fill && w_wr_tail) begin
            w_tail_word_n = i_mem_rdata;
            w_tail_pc_n   = r_pc;
        end else begin
            w_tail_word_n = r_tail_word;
            w_tail_pc_n   = r_tail_pc;
        end
    end
`else
    // Next buffer contents: the single entry is overwritten by a kept word.
    always_comb begin
        w_head_word_n = r_head_word;
        w_head_pc_n   = r_head_pc;
        if (w_fill) begin
            w_head_word_n = i_mem_rdata;
            w_head_pc_n   = r_pc;
        end else begin
            w_head_word_n = r_head_word;
            w_head_pc_n   = r_head_pc;
        end
    end
`endif

    // Instruction buffer registers; a jump empties it after any accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count     <= 2'd0;
            r_head_word <= {WIDTH{1'b0}};
            r_head_pc   <= {WIDTH{1'b0}};
`ifdef FETCH_PREFETCH_EN
            r_tail_word <= {WIDTH{1'b0}};
            r_tail_pc   <= {WIDTH{1'b0}};
`endif
        end else begin
            if (i_jmp_en) begin
                r_count <= 2'd0;
            end else begin
                r_count <= w_count_n;
            end
            r_head_word <= w_head_word_n;
            r_head_pc   <= w_head_pc_n;
`ifdef FETCH_PREFETCH_EN
            r_tail_word <= w_tail_word_n;
            r_tail_pc   <= w_tail_pc_n;
`endif
        end
    end

    // Fetch sequencer: pc, state and the registered memory request outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else if (i_jmp_en) begin
            r_pc <= i_jmp_addr;
            if (w_pending) begin
                // Read still in flight: keep the request steady until it returns.
                r_state  <= S_DRAIN;
                r_mem_rd <= 1'b1;
            end else begin
                r_state    <= S_REQ;
                r_mem_rd   <= 1'b1;
                r_mem_addr <= i_jmp_addr;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_pc;
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_pc       <= w_pc_inc;
                        r_mem_addr <= w_pc_inc;
                        if (w_room) begin
                            r_state  <= S_REQ;
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_state  <= S_FULL;
                            r_mem_rd <= 1'b0;
                        end
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_FULL: begin
                    if (w_accept) begin
                        r_state    <= S_REQ;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_pc;
                    end else begin
                        r_state <= S_FULL;
                    end
                end
                S_DRAIN: begin
                    if (i_mem_ready) begin
                        // Stale word is dropped; start at the pending target.
                        r_state    <= S_REQ;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_pc;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_mem_addr;
    assign o_iv       = (r_count != 2'd0);
    assign o_ipc      = r_head_pc;
    assign o_op       = r_head_word[31:26];
    assign o_rd_idx   = r_head_word[25:22];
    assign o_ra_idx   = r_head_word[21:18];
    assign o_rb_idx   = r_head_word[3:0];
    assign o_im       = r_head_word[15:0];

endmodule

// File: tb/tb_fetch_unit2.sv
// Testbench for fetch_unit2: a memory responder with configurable latency,
// a program-order reference model of the consumer's instruction stream,
// and directed scenarios for reset, decode, backpressure and redirects.
module tb_fetch_unit2;

    localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_addr = 32'd0;
    logic        iaccept = 1'b0;

    logic [31:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_iv;
    logic [5:0]  o_op;
    logic [3:0]  o_rd_idx;
    logic [3:0]  o_ra_idx;
    logic [3:0]  o_rb_idx;
    logic [15:0] o_im;
    logic [31:0] o_ipc;

    always #5 clk = ~clk;

    fetch_unit2 #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_reset(reset),
        .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .i_jmp_en(jmp_en), .i_jmp_addr(jmp_addr),
        .o_iv(o_iv), .i_iaccept(iaccept),
        .o_op(o_op), .o_rd_idx(o_rd_idx), .o_ra_idx(o_ra_idx),
        .o_rb_idx(o_rb_idx), .o_im(o_im), .o_ipc(o_ipc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // memory responder state
    bit          mem_always = 1'b0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          wait_cnt = 0;
    int          cur_lat = 0;
    bit          prev_pend = 1'b0;
    bit          prev_rst = 1'b1;
    logic [31:0] prev_addr = 32'd0;

    // reference model: program-order address of the next delivered instruction
    logic [31:0] exp_pc = RPC;
    int          n_acc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h5A84_C3F2;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0F1E_2D3C;
    endfunction

    // One cycle: observe at negedge, answer memory, apply inputs, update model.
    task automatic tick(input bit rst, input bit acc, input bit jmp, input logic [31:0] ja);
        logic [31:0] w;
        logic [33:0] ef;
        logic [33:0] af;
        @(negedge clk);
        if (prev_pend && !prev_rst) begin
            n_cmp++;
            if (o_mem_rd !== 1'b1 || o_mem_addr !== prev_addr) begin
                n_err++;
                $display("FAIL addr_stable: rd=%b addr=%h required rd=1 addr=%h", o_mem_rd, o_mem_addr, prev_addr);
            end
        end
        if (mem_always) begin
            mem_ready = 1'b1;
            mem_rdata = mem_word(o_mem_addr);
        end else if (o_mem_rd) begin
            if (wait_cnt >= cur_lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(o_mem_addr);
                wait_cnt  = 0;
                cur_lat   = $urandom_range(lat_max, lat_min);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        prev_pend = o_mem_rd && !mem_ready;
        prev_addr = o_mem_addr;
        prev_rst  = rst;
        reset    = rst;
        iaccept  = acc;
        jmp_en   = jmp;
        jmp_addr = ja;
        if (rst) begin
            exp_pc = RPC;
        end else begin
            if (o_iv && acc) begin
                w  = mem_word(exp_pc);
                ef = {w[31:26], w[25:22], w[21:18], w[3:0], w[15:0]};
                af = {o_op, o_rd_idx, o_ra_idx, o_rb_idx, o_im};
                n_cmp++;
                if (o_ipc !== exp_pc) begin
                    n_err++;
                    $display("FAIL sb_ipc: ipc=%h required %h", o_ipc, exp_pc);
                end
                n_cmp++;
                if (af !== ef) begin
                    n_err++;
                    $display("FAIL sb_fields: fields=%h required %h (pc %h)", af, ef, exp_pc);
                end
                exp_pc = exp_pc + 32'd1;
                n_acc++;
            end
            if (jmp) exp_pc = ja;
        end
    endtask

    task automatic set_lat(input int lo, input int hi);
        mem_always = 1'b0;
        lat_min = lo;
        lat_max = hi;
        cur_lat = lo;
        wait_cnt = 0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        int na;
        int first_iv;
        logic [31:0] first_ipc;
        na = 0;
        first_iv = -1;
        first_ipc = 32'd0;
        mem_always = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: %b required 0", o_mem_rd); end
        n_cmp++; if (o_mem_addr !== RPC) begin n_err++; $display("FAIL rst_mem_addr: %h required %h", o_mem_addr, RPC); end
        n_cmp++; if (o_iv !== 1'b0) begin n_err++; $display("FAIL rst_iv: %b required 0", o_iv); end
        n_cmp++; if ({o_op, o_rd_idx, o_ra_idx, o_rb_idx, o_im} !== 34'd0) begin n_err++; $display("FAIL rst_fields: %h required 0", {o_op, o_rd_idx, o_ra_idx, o_rb_idx, o_im}); end
        n_cmp++; if (o_ipc !== 32'd0) begin n_err++; $display("FAIL rst_ipc: %h required 0", o_ipc); end
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_mem_rd !== 1'b0) begin n_err++; $display("FAIL idle_mem_rd: %b required 0", o_mem_rd); end
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0);
            if (o_mem_rd && na < 3) begin addrs[na] = o_mem_addr; na++; end
            if (o_iv && first_iv < 0) begin first_iv = k; first_ipc = o_ipc; end
        end
        n_cmp++; if (na != 3) begin n_err++; $display("FAIL start_nreq: %0d required 3", na); end
        for (int i = 0; i < 3 && i < na; i++) begin
            n_cmp++;
            if (addrs[i] !== RPC + 32'(i)) begin n_err++; $display("FAIL start_addr%0d: %h required %h", i, addrs[i], RPC + 32'(i)); end
        end
        n_cmp++; if (first_iv != 2) begin n_err++; $display("FAIL start_iv_cycle: %0d required 2", first_iv); end
        n_cmp++; if (first_ipc !== RPC) begin n_err++; $display("FAIL start_ipc: %h required %h", first_ipc, RPC); end
    endtask

    task automatic test_decode();
        set_lat(0, 0);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b0) begin n_err++; $display("FAIL dec_flush_iv: %b required 0", o_iv); end
        n_cmp++; if (o_mem_rd !== 1'b1 || o_mem_addr !== 32'h300) begin n_err++; $display("FAIL dec_req: rd=%b addr=%h required 1/300", o_mem_rd, o_mem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b1 || o_ipc !== 32'h300) begin n_err++; $display("FAIL dec_iv: iv=%b ipc=%h required 1/300", o_iv, o_ipc); end
        n_cmp++; if (o_op !== 6'h16) begin n_err++; $display("FAIL dec_op: %h required 16", o_op); end
        n_cmp++; if (o_rd_idx !== 4'hA) begin n_err++; $display("FAIL dec_rd: %h required a", o_rd_idx); end
        n_cmp++; if (o_ra_idx !== 4'h1) begin n_err++; $display("FAIL dec_ra: %h required 1", o_ra_idx); end
        n_cmp++; if (o_rb_idx !== 4'h2) begin n_err++; $display("FAIL dec_rb: %h required 2", o_rb_idx); end
        n_cmp++; if (o_im !== 16'hC3F2) begin n_err++; $display("FAIL dec_im: %h required c3f2", o_im); end
        tick(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_backpressure();
        int fetched;
        int a0;
        fetched = 0;
        set_lat(0, 0);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            if (o_mem_rd && mem_ready) fetched++;
        end
        n_cmp++; if (fetched != DEPTH) begin n_err++; $display("FAIL bp_fetched: %0d required %0d", fetched, DEPTH); end
        n_cmp++; if (o_mem_rd !== 1'b0) begin n_err++; $display("FAIL bp_mem_rd: %b required 0", o_mem_rd); end
        a0 = n_acc;
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b1 || o_ipc !== 32'h400) begin n_err++; $display("FAIL bp_head: iv=%b ipc=%h required 1/400", o_iv, o_ipc); end
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (n_acc - a0 < DEPTH + 1) begin n_err++; $display("FAIL bp_release: %0d accepted required >= %0d", n_acc - a0, DEPTH + 1); end
    endtask

    task automatic test_redirect_drain();
        bit found;
        logic [31:0] got;
        found = 1'b0;
        got = 32'd0;
        set_lat(2, 2);
        tick(1'b1, 1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_mem_rd !== 1'b1 || o_mem_addr !== RPC) begin n_err++; $display("FAIL drn_start: rd=%b addr=%h required 1/%h", o_mem_rd, o_mem_addr, RPC); end
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_mem_rd !== 1'b1 || o_mem_addr !== RPC || mem_ready !== 1'b1) begin n_err++; $display("FAIL drn_hold: rd=%b addr=%h rdy=%b required 1/%h/1", o_mem_rd, o_mem_addr, mem_ready, RPC); end
        tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (o_mem_rd !== 1'b1 || o_mem_addr !== 32'h200 || o_iv !== 1'b0) begin n_err++; $display("FAIL drn_target: rd=%b addr=%h iv=%b required 1/200/0", o_mem_rd, o_mem_addr, o_iv); end
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0);
            if (o_iv) begin found = 1'b1; got = o_ipc; end
        end
        n_cmp++; if (!found || got !== 32'h200) begin n_err++; $display("FAIL drn_ipc: found=%b ipc=%h required 1/200", found, got); end
    endtask

    task automatic test_collisions();
        int a0;
        set_lat(0, 0);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0600);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b1 || o_ipc !== 32'h600) begin n_err++; $display("FAIL col_pre: iv=%b ipc=%h required 1/600", o_iv, o_ipc); end
        a0 = n_acc;
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0700);
        n_cmp++; if (n_acc - a0 != 1) begin n_err++; $display("FAIL col_acc: %0d accepted required 1", n_acc - a0); end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b0 || o_mem_rd !== 1'b1 || o_mem_addr !== 32'h700) begin n_err++; $display("FAIL col_flush: iv=%b rd=%b addr=%h required 0/1/700", o_iv, o_mem_rd, o_mem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b1 || o_ipc !== 32'h700) begin n_err++; $display("FAIL col_restart: iv=%b ipc=%h required 1/700", o_iv, o_ipc); end
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0900);
        n_cmp++; if (o_mem_rd !== 1'b1 || mem_ready !== 1'b1 || o_mem_addr !== 32'h800) begin n_err++; $display("FAIL col_rdy_pre: rd=%b rdy=%b addr=%h required 1/1/800", o_mem_rd, mem_ready, o_mem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b0 || o_mem_addr !== 32'h900) begin n_err++; $display("FAIL col_rdy_drop: iv=%b addr=%h required 0/900", o_iv, o_mem_addr); end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        n_cmp++; if (o_iv !== 1'b1 || o_ipc !== 32'h900) begin n_err++; $display("FAIL col_rdy_ipc: iv=%b ipc=%h required 1/900", o_iv, o_ipc); end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic test_pc_wrap();
        logic [31:0] addrs [2];
        int na;
        na = 0;
        set_lat(0, 0);
        tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0);
            if (o_mem_rd && mem_ready && na < 2) begin addrs[na] = o_mem_addr; na++; end
        end
        n_cmp++; if (na != 2) begin n_err++; $display("FAIL wrap_n: %0d required 2", na); end
        if (na == 2) begin
            n_cmp++; if (addrs[0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_a0: %h required ffffffff", addrs[0]); end
            n_cmp++; if (addrs[1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_a1: %h required 00000000", addrs[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int exp_n;
        exp_n = (DEPTH == 2) ? 20 : 10;
        set_lat(0, 0);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_1000);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
        a0 = n_acc;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 32'd0);
        n_cmp++; if (n_acc - a0 != exp_n) begin n_err++; $display("FAIL b2b_rate: %0d in 20 cycles required %0d", n_acc - a0, exp_n); end
    endtask

    task automatic test_random();
        int a0;
        bit rst;
        bit acc;
        bit jmp;
        logic [31:0] ja;
        a0 = n_acc;
        set_lat(0, 3);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199, 0) == 0);
            acc = ($urandom_range(9, 0) < 7);
            jmp = !rst && ($urandom_range(29, 0) == 0);
            ja  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1, 0))) : $urandom;
            tick(rst, acc, jmp, ja);
        end
        n_cmp++; if (n_acc - a0 < 200) begin n_err++; $display("FAIL rnd_progress: %0d accepted required >= 200", n_acc - a0); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_redirect_drain();
        test_collisions();
        test_pc_wrap();
        test_back_to_back();
        test_random();
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
